// File: rtl/fb_line_fetcher.sv
// Framebuffer read-path fetcher: issues burst reads for a whole frame from one of
// NUM_BUFFERS buffers and streams the returned words out through a FWFT pixel FIFO.
module fb_line_fetcher #(
  parameter int                H_RES       = 800,
  parameter int                V_RES       = 600,
  parameter int                ADDR_W      = 24,
  parameter int                DATA_W      = 16,
  parameter int                BURST_LEN   = 8,
  parameter int                NUM_BUFFERS = 2,
  parameter int                FIFO_DEPTH  = 512,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                frame_start_i,
  input  logic                swap_req_i,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output logic [ADDR_W-1:0]   rd_addr_o,
  input  logic                resp_valid_i,
  input  logic [DATA_W-1:0]   resp_data_i,
  input  logic                resp_last_i,
  output logic                resp_ready_o,
  output logic                m_tvalid_o,
  input  logic                m_tready_i,
  output logic [DATA_W-1:0]   m_tdata_o,
  output logic                m_tuser_o,
  output logic                m_tlast_o,
  output logic [((NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1)-1:0] front_buf_o,
  output logic                busy_o,
  output logic                proto_err_o
);

  localparam int TOTAL  = H_RES * V_RES;
  localparam int FB_W   = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
  localparam int PIX_W  = $clog2(TOTAL + 1);
  localparam int COL_W  = $clog2(H_RES + 1);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ENT_W  = DATA_W + 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_DONE  = 3'd3,
    S_FLUSH = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [FB_W-1:0]     front_q, front_d;
  logic                swap_pend_q, swap_pend_d;
  logic                rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                resp_ready_q, resp_ready_d;
  logic                busy_q, busy_d;
  logic                proto_err_q, proto_err_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];

  logic beat_s, last_beat_s, more_s, push_s, pop_s, tuser_s, tlast_s;
  logic [ENT_W-1:0] head_s;

  assign beat_s      = resp_valid_i && resp_ready_q;
  assign last_beat_s = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign more_s      = (int'(pix_q) + BURST_LEN) < TOTAL;
  assign pop_s       = (cnt_q != '0) && m_tready_i;
  assign tuser_s     = (pix_q == '0) && (beat_q == '0);
  assign tlast_s     = (col_q + COL_W'(beat_q)) == COL_W'(H_RES - 1);

  // Next-state, pointer and FIFO bookkeeping; frame_start_i overrides the normal flow.
  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    col_d       = col_q;
    beat_d      = beat_q;
    front_d     = front_q;
    push_s      = 1'b0;
    swap_pend_d = swap_pend_q;
    proto_err_d = proto_err_q;

    case (state_q)
      S_IDLE, S_DONE: state_d = state_q;
      S_REQ: begin
        if (rd_valid_q && rd_ready_i) begin
          state_d = S_RESP;
          beat_d  = '0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RESP, S_FLUSH: begin
        if (beat_s) begin
          push_s = (state_q == S_RESP);
          if (last_beat_s) begin
            beat_d = '0;
            if (state_q == S_FLUSH) begin
              state_d = S_REQ;
            end else if (more_s) begin
              state_d = S_REQ;
              pix_d   = pix_q + PIX_W'(BURST_LEN);
              col_d   = ((col_q + COL_W'(BURST_LEN)) == COL_W'(H_RES)) ? '0 : col_q + COL_W'(BURST_LEN);
            end else begin
              state_d = S_DONE;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Beat count decides burst end; resp_last_i is only cross-checked against it.
    if (beat_s && (last_beat_s != resp_last_i)) begin
      proto_err_d = 1'b1;
    end else begin
      proto_err_d = proto_err_q;
    end

    if (frame_start_i) begin
      pix_d       = '0;
      col_d       = '0;
      swap_pend_d = 1'b0;
      if (swap_pend_q || swap_req_i) begin
        front_d = (front_q == FB_W'(NUM_BUFFERS - 1)) ? '0 : front_q + FB_W'(1);
      end else begin
        front_d = front_q;
      end
      case (state_q)
        S_RESP:  state_d = (beat_s && last_beat_s) ? S_REQ : S_FLUSH;
        S_FLUSH: state_d = state_d;
        // A request accepted on the restart edge is already in flight: drain it.
        S_REQ: begin
          if (rd_valid_q && rd_ready_i) begin
            state_d = S_FLUSH;
            beat_d  = '0;
          end else begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      swap_pend_d = swap_pend_q | swap_req_i;
      wr_ptr_d    = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d    = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      cnt_d       = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    rd_valid_d   = (state_d == S_REQ) && (cnt_d <= CNT_W'(FIFO_DEPTH - BURST_LEN)) &&
                   !(frame_start_i && (state_q == S_REQ));
    rd_addr_d    = rd_valid_d ? (BASE_ADDR + ADDR_W'(front_d) * ADDR_W'(TOTAL) + ADDR_W'(pix_d)) : '0;
    resp_ready_d = (state_d == S_RESP) || (state_d == S_FLUSH);
    busy_d       = (state_d == S_REQ) || (state_d == S_RESP) || (state_d == S_FLUSH);
  end

  // Control and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      pix_q        <= '0;
      col_q        <= '0;
      beat_q       <= '0;
      front_q      <= '0;
      swap_pend_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_addr_q    <= '0;
      resp_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      proto_err_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      col_q        <= col_d;
      beat_q       <= beat_d;
      front_q      <= front_d;
      swap_pend_q  <= swap_pend_d;
      rd_valid_q   <= rd_valid_d;
      rd_addr_q    <= rd_addr_d;
      resp_ready_q <= resp_ready_d;
      busy_q       <= busy_d;
      proto_err_q  <= proto_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Pixel FIFO storage, tagged with tuser/tlast.
  always_ff @(posedge clk_i) begin
    if (push_s && !frame_start_i) begin
      mem_q[wr_ptr_q] <= {tuser_s, tlast_s, resp_data_i};
    end
  end

  // Stream outputs are forced to zero while the FIFO is empty so reset leaves them low.
  assign head_s       = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign m_tvalid_o   = (cnt_q != '0);
  assign m_tdata_o    = head_s[DATA_W-1:0];
  assign m_tlast_o    = head_s[DATA_W];
  assign m_tuser_o    = head_s[DATA_W+1];
  assign rd_valid_o   = rd_valid_q;
  assign rd_addr_o    = rd_addr_q;
  assign resp_ready_o = resp_ready_q;
  assign front_buf_o  = front_q;
  assign busy_o       = busy_q;
  assign proto_err_o  = proto_err_q;

endmodule
